// File: rtl/enc_cnt_pkg.sv
// Shared state encoding and sizing helper for the multi-channel encoder counter.
package enc_cnt_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT_Z = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    typedef enum logic [1:0] {
        StIdle   = ST_IDLE,
        StWaitZ  = ST_WAIT_Z,
        StActive = ST_ACTIVE
    } ch_state_e;

    // Select width never drops below one bit, even for a single channel.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/enc_cnt_ch.sv
// One encoder channel: input synchronisers, edge detect, arm/index FSM, counter
// and sticky overflow.
module enc_cnt_ch
    import enc_cnt_pkg::*;
#(
    parameter int CNT_W       = 64,
    parameter int SYNC_STAGES = 2,
    parameter bit Z_GATE      = 1'b1,
    parameter bit CLR_ON_Z    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             a,
    input  logic             z,
    output logic             a_stb,
    output logic             z_stb,
    output logic [CNT_W-1:0] cnt,
    output logic             overflow,
    output logic             ready
);

    logic [SYNC_STAGES-1:0] a_sync_q, z_sync_q;
    logic                   a_prev_q, z_prev_q;
    logic                   a_edge, z_edge;
    ch_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   a_stb_q, a_stb_d;
    logic                   z_stb_q, z_stb_d;

    assign a_edge = a_sync_q[SYNC_STAGES-1] & ~a_prev_q;
    assign z_edge = z_sync_q[SYNC_STAGES-1] & ~z_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sync_q <= '0;
            z_sync_q <= '0;
            a_prev_q <= 1'b0;
            z_prev_q <= 1'b0;
            state_q  <= StIdle;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            a_stb_q  <= 1'b0;
            z_stb_q  <= 1'b0;
        end else begin
            a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], a};
            z_sync_q <= {z_sync_q[SYNC_STAGES-2:0], z};
            a_prev_q <= a_sync_q[SYNC_STAGES-1];
            z_prev_q <= z_sync_q[SYNC_STAGES-1];
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            a_stb_q  <= a_stb_d;
            z_stb_q  <= z_stb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        a_stb_d = 1'b0;
        z_stb_d = z_edge && (state_q != StIdle);
        // Disarm holds count and overflow so the last value stays readable.
        if (!arm) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = Z_GATE ? StWaitZ : StActive;
                end
                StWaitZ: begin
                    if (z_edge) state_d = StActive;
                end
                StActive: begin
                    if (CLR_ON_Z && z_edge) begin
                        cnt_d   = a_edge ? CNT_W'(1) : '0;
                        a_stb_d = a_edge;
                    end else if (a_edge) begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        a_stb_d = 1'b1;
                        if (&cnt_q) ovf_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign a_stb    = a_stb_q;
    assign z_stb    = z_stb_q;
    assign cnt      = cnt_q;
    assign overflow = ovf_q;
    assign ready    = (state_q == StActive);

endmodule

// File: rtl/enc_cnt_multi.sv
// N-channel encoder pulse counter: independent channel instances, packed outputs
// and a registered per-channel count select for the readout path.
module enc_cnt_multi
    import enc_cnt_pkg::*;
#(
    parameter int  N_CH        = 2,
    parameter int  CNT_W       = 64,
    parameter int  SYNC_STAGES = 2,
    parameter bit  Z_GATE      = 1'b1,
    parameter bit  CLR_ON_Z    = 1'b0,
    localparam int SEL_W       = sel_width(N_CH)
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic [N_CH-1:0]       i_arm,
    input  logic [N_CH-1:0]       i_a,
    input  logic [N_CH-1:0]       i_z,
    input  logic [SEL_W-1:0]      i_sel,
    output logic [N_CH-1:0]       o_a,
    output logic [N_CH-1:0]       o_z,
    output logic [N_CH*CNT_W-1:0] o_cnt,
    output logic [CNT_W-1:0]      o_sel_cnt,
    output logic [N_CH-1:0]       o_overflow,
    output logic [N_CH-1:0]       o_ready
);

    logic [CNT_W-1:0] cnt_arr [N_CH];
    logic [CNT_W-1:0] sel_cnt_q, sel_cnt_d;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        enc_cnt_ch #(
            .CNT_W      (CNT_W),
            .SYNC_STAGES(SYNC_STAGES),
            .Z_GATE     (Z_GATE),
            .CLR_ON_Z   (CLR_ON_Z)
        ) u_ch (
            .clk     (clk),
            .rst     (i_rst),
            .arm     (i_arm[k]),
            .a       (i_a[k]),
            .z       (i_z[k]),
            .a_stb   (o_a[k]),
            .z_stb   (o_z[k]),
            .cnt     (o_cnt[k*CNT_W +: CNT_W]),
            .overflow(o_overflow[k]),
            .ready   (o_ready[k])
        );
        assign cnt_arr[k] = o_cnt[k*CNT_W +: CNT_W];
    end

    // Selects beyond the last channel read back as zero.
    always_comb begin
        sel_cnt_d = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (i_sel == SEL_W'(k)) sel_cnt_d = cnt_arr[k];
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) sel_cnt_q <= '0;
        else       sel_cnt_q <= sel_cnt_d;
    end

    assign o_sel_cnt = sel_cnt_q;

endmodule

// File: tb/tb_enc_cnt_multi.sv
// Bench for enc_cnt_multi: a gated 4-channel instance checked through a strobe
// scoreboard, plus a single-channel instance with clear-on-index.
module tb_enc_cnt_multi;

    localparam int NCH = 4;
    localparam int CW  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [NCH-1:0] arm, a, z;
    logic [1:0]     sel;
    logic [NCH-1:0] o_a, o_z, o_ovf, o_rdy;
    logic [NCH*CW-1:0] o_cnt;
    logic [CW-1:0]  o_sel;

    logic       arm_b, a_b, z_b;
    logic [0:0] sel_b;
    logic [0:0] o_a_b, o_z_b, ovf_b, rdy_b;
    logic [CW-1:0] cnt_b, sel_cnt_b;

    enc_cnt_multi #(
        .N_CH(NCH), .CNT_W(CW), .SYNC_STAGES(2), .Z_GATE(1'b1), .CLR_ON_Z(1'b0)
    ) dut (
        .clk(clk), .i_rst(rst), .i_arm(arm), .i_a(a), .i_z(z), .i_sel(sel),
        .o_a(o_a), .o_z(o_z), .o_cnt(o_cnt), .o_sel_cnt(o_sel),
        .o_overflow(o_ovf), .o_ready(o_rdy)
    );

    enc_cnt_multi #(
        .N_CH(1), .CNT_W(CW), .SYNC_STAGES(2), .Z_GATE(1'b0), .CLR_ON_Z(1'b1)
    ) dut_b (
        .clk(clk), .i_rst(rst), .i_arm(arm_b), .i_a(a_b), .i_z(z_b), .i_sel(sel_b),
        .o_a(o_a_b), .o_z(o_z_b), .o_cnt(cnt_b), .o_sel_cnt(sel_cnt_b),
        .o_overflow(ovf_b), .o_ready(rdy_b)
    );

    typedef struct packed {
        logic          is_z;
        logic [1:0]    ch;
        logic [CW-1:0] cnt;
        logic          ovf;
    } ev_t;

    ev_t           sb_q[$];
    int            checks = 0;
    int            failures = 0;
    bit            mon_en = 1'b0;
    int            zb_cnt = 0;
    logic [CW-1:0] m_cnt [NCH];
    logic          m_ovf [NCH];
    int            m_st  [NCH];   // 0 idle, 1 wait for index, 2 active

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input bit is_z, input int k);
        ev_t e;
        e.is_z = is_z;
        e.ch   = 2'(k);
        e.cnt  = m_cnt[k];
        e.ovf  = m_ovf[k];
        sb_q.push_back(e);
    endtask

    // Expected strobes for one edge pair on channel k.
    task automatic model_edge(input int k, input bit av, input bit zv);
        if (m_st[k] == 1) begin
            if (zv) begin
                m_st[k] = 2;
                push_ev(1'b1, k);
            end
        end else if (m_st[k] == 2) begin
            if (av) begin
                m_cnt[k] = m_cnt[k] + 8'd1;
                if (m_cnt[k] == 8'd0) m_ovf[k] = 1'b1;
                push_ev(1'b0, k);
            end
            if (zv) push_ev(1'b1, k);
        end
    endtask

    task automatic pop_check(input bit is_z, input int k);
        ev_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe ch%0d z=%0d: got strobe expected none", k, is_z);
            return;
        end
        e = sb_q.pop_front();
        chk($sformatf("sb_kind_ch%0d", k), {61'd0, is_z, 2'(k)}, {61'd0, e.is_z, e.ch});
        if (!is_z) begin
            chk($sformatf("sb_cnt_ch%0d", k), 64'(o_cnt[k*CW +: CW]), 64'(e.cnt));
            chk($sformatf("sb_ovf_ch%0d", k), 64'(o_ovf[k]), 64'(e.ovf));
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < NCH; k++) begin
                if (o_a[k]) pop_check(1'b0, k);
                if (o_z[k]) pop_check(1'b1, k);
            end
            if (o_z_b[0]) zb_cnt++;
        end
    end

    task automatic pulse(input logic [NCH-1:0] am, input logic [NCH-1:0] zm);
        for (int k = 0; k < NCH; k++) model_edge(k, am[k], zm[k]);
        @(posedge clk); #1; a = am; z = zm;
        @(posedge clk); #1; a = '0; z = '0;
    endtask

    task automatic pulse_b(input logic av, input logic zv);
        @(posedge clk); #1; a_b = av; z_b = zv;
        @(posedge clk); #1; a_b = 1'b0; z_b = 1'b0;
    endtask

    logic [7:0] vec [8];
    int         exp_sel [NCH];

    initial begin
        // {a, z} per step
        vec[0] = 8'b0000_1110; vec[1] = 8'b0011_0000; vec[2] = 8'b1010_0000;
        vec[3] = 8'b0110_0001; vec[4] = 8'b1111_0000; vec[5] = 8'b0101_1000;
        vec[6] = 8'b0100_0000; vec[7] = 8'b1011_0110;
        exp_sel[0] = 10; exp_sel[1] = 5; exp_sel[2] = 4; exp_sel[3] = 3;
        for (int k = 0; k < NCH; k++) begin
            m_cnt[k] = '0; m_ovf[k] = 1'b0; m_st[k] = 1;
        end

        rst = 1'b1; arm = '1; a = '0; z = '0; sel = '0;
        arm_b = 1'b1; a_b = 1'b0; z_b = 1'b0; sel_b = '0;

        // Reset with arm high and A toggling
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            a = ~a; a_b = ~a_b;
            chk("rst_cnt", 64'(o_cnt), 64'd0);
            chk("rst_flags", {48'd0, o_a, o_z, o_ovf, o_rdy}, 64'd0);
            chk("rst_sel", 64'(o_sel), 64'd0);
            chk("rst_b", {52'd0, cnt_b, o_a_b, o_z_b, ovf_b, rdy_b}, 64'd0);
        end
        a = '0; a_b = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {52'd0, o_rdy, rdy_b, o_ovf[2:0]}, 64'd0);
        mon_en = 1'b1;
        @(posedge clk); #1;
        chk("arm_ready", {62'd0, o_rdy[0], rdy_b}, 64'd1);

        // Index gating on ch0: A before Z ignored, ready one cycle after detect
        repeat (3) pulse(4'b0001, 4'b0000);
        model_edge(0, 1'b0, 1'b1);
        @(posedge clk); #1; z = 4'b0001;
        @(posedge clk); #1; z = '0;
        @(posedge clk); #1; chk("zgate_ready_pre", 64'(o_rdy[0]), 64'd0);
        @(posedge clk); #1; chk("zgate_ready_post", 64'(o_rdy[0]), 64'd1);
        chk("zgate_cnt0", 64'(o_cnt[7:0]), 64'd0);
        repeat (5) pulse(4'b0001, 4'b0000);
        repeat (4) @(posedge clk);
        #1 chk("zgate_cnt5", 64'(o_cnt[7:0]), 64'd5);

        // Latency: exactly three edges from A rise to count update
        model_edge(0, 1'b1, 1'b0);
        @(posedge clk); #1; a = 4'b0001;
        @(posedge clk); #1; a = '0; chk("lat_e1", 64'(o_cnt[7:0]), 64'd5);
        @(posedge clk); #1; chk("lat_e2", {55'd0, o_a[0], o_cnt[7:0]}, 64'd5);
        @(posedge clk); #1; chk("lat_e3", {55'd0, o_a[0], o_cnt[7:0]}, 64'h106);

        // Mixed A/Z vectors across all channels
        for (int i = 0; i < 8; i++) pulse(vec[i][7:4], vec[i][3:0]);
        repeat (5) @(posedge clk);
        #1 chk("all_ready", 64'(o_rdy), 64'hF);
        for (int s = 0; s < NCH; s++) begin
            @(posedge clk); #1; sel = 2'(s);
            @(posedge clk); #1; chk($sformatf("sel%0d", s), 64'(o_sel), 64'(exp_sel[s]));
        end

        // Wrap on ch3 after a re-arm
        arm[3] = 1'b0; m_st[3] = 0;
        @(posedge clk); #1;
        chk("disarm_hold", {55'd0, o_rdy[3], o_cnt[31:24]}, 64'd3);
        arm[3] = 1'b1; m_st[3] = 1; m_cnt[3] = '0; m_ovf[3] = 1'b0;
        @(posedge clk); #1;
        chk("rearm_clear", 64'(o_cnt[31:24]), 64'd0);
        pulse(4'b1000, 4'b1000);
        repeat (257) pulse(4'b1000, 4'b0000);
        repeat (5) @(posedge clk);
        #1 chk("wrap", {55'd0, o_ovf[3], o_cnt[31:24]}, 64'h101);
        arm[3] = 1'b0; m_st[3] = 0;
        pulse(4'b1000, 4'b0000);
        repeat (5) @(posedge clk);
        #1 chk("wrap_hold", {54'd0, o_rdy[3], o_ovf[3], o_cnt[31:24]}, 64'h101);
        arm[3] = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("wrap_rearm", {55'd0, o_ovf[3], o_cnt[31:24]}, 64'd0);
        chk("others_kept", 64'(o_cnt[23:0]), {40'd0, 8'd4, 8'd5, 8'd10});

        // Clear-on-index instance
        repeat (7) pulse_b(1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1 chk("clrz_cnt7", 64'(cnt_b), 64'd7);
        pulse_b(1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1 chk("clrz_za", 64'(cnt_b), 64'd1);
        @(posedge clk); #1; sel_b = 1'b0;
        @(posedge clk); #1; chk("clrz_sel0", 64'(sel_cnt_b), 64'd1);
        sel_b = 1'b1;
        @(posedge clk); #1; chk("sel_out_of_range", 64'(sel_cnt_b), 64'd0);
        pulse_b(1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1 chk("clrz_z", 64'(cnt_b), 64'd0);
        chk("clrz_zstrobes", 64'(zb_cnt), 64'd2);

        repeat (3) @(posedge clk);
        chk("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
